sdrc_bank_req_queue: RTL and testbench

- Responder end of the request-generator-to-bank-control handshake (r2b_* / b2r_*).
- Accepts page-split request chunks, buffers them in an in-order FIFO and throttles the generator through b2r_arb_ok.
- Presents the oldest chunk to the transfer/bank sequencing logic (b2x_* / x2b_ack), with a per-bank open-row hit indication.

---
 rtl/sdrc_bank_req_queue.sv | 110 +++++++++++
 tb/tb_sdrc_bank_req_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_bank_req_queue.sv
// In-order request-chunk FIFO between the request generator and bank control.
// It throttles the generator and flags when the head row is already open in its bank.
module sdrc_bank_req_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int LEN_W = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     r2b_req,
  input  logic [ID_W-1:0]          r2b_req_id,
  input  logic                     r2b_start,
  input  logic                     r2b_last,
  input  logic                     r2b_wrap,
  input  logic                     r2b_write,
  input  logic [1:0]               r2b_ba,
  input  logic [12:0]              r2b_raddr,
  input  logic [12:0]              r2b_caddr,
  input  logic [LEN_W-1:0]         r2b_len,
  output logic                     b2r_ack,
  output logic                     b2r_arb_ok,
  output logic                     b2x_req,
  output logic [ID_W-1:0]          b2x_id,
  output logic                     b2x_start,
  output logic                     b2x_last,
  output logic                     b2x_wrap,
  output logic                     b2x_write,
  output logic [1:0]               b2x_ba,
  output logic [12:0]              b2x_raddr,
  output logic [12:0]              b2x_caddr,
  output logic [LEN_W-1:0]         b2x_len,
  output logic                     b2x_row_hit,
  output logic [$clog2(DEPTH):0]   b2x_count,
  input  logic                     x2b_ack,
  input  logic                     x2b_pre_all
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ID_W + 4 + 2 + 13 + 13 + LEN_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    bank_open_q, bank_open_d;
  logic [12:0]   bank_row_q [4];
  logic [12:0]   bank_row_d [4];
  logic          push, pop;
  logic [EW-1:0] head;
  logic [CW-1:0] free_slots;

  // No bypass: a full queue refuses a push even when the head leaves this cycle.
  assign push       = r2b_req & (count_q != DEPTH_C);
  assign pop        = (count_q != '0) & x2b_ack;
  assign head       = mem_q[rd_ptr_q];
  assign free_slots = DEPTH_C - count_q;

  assign {b2x_id, b2x_start, b2x_last, b2x_wrap, b2x_write,
          b2x_ba, b2x_raddr, b2x_caddr, b2x_len} = head;

  assign b2r_ack     = push;
  assign b2r_arb_ok  = free_slots >= TWO_C;
  assign b2x_req     = count_q != '0;
  assign b2x_count   = count_q;
  assign b2x_row_hit = b2x_req & bank_open_q[b2x_ba] & (bank_row_q[b2x_ba] == b2x_raddr);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    bank_open_d = bank_open_q;
    bank_row_d  = bank_row_q;
    if (push) begin
      mem_d[wr_ptr_q] = {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
                         r2b_ba, r2b_raddr, r2b_caddr, r2b_len};
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d               = rd_ptr_q + AW'(1);
      bank_open_d[b2x_ba]    = 1'b1;
      bank_row_d[b2x_ba]     = b2x_raddr;
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // Precharge-all wins over the open-row update of a same-cycle pop.
    if (x2b_pre_all) bank_open_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bank_open_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 4; i++) bank_row_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bank_open_q <= bank_open_d;
      mem_q       <= mem_d;
      bank_row_q  <= bank_row_d;
    end
  end
endmodule

// File: tb/tb_sdrc_bank_req_queue.sv
// Directed bench for sdrc_bank_req_queue: a per-cycle vector table plus
// hand-written sequences for field pass-through, page splits, wrap-around and async reset.
module tb_sdrc_bank_req_queue;
  localparam int DEPTH = 4;
  localparam int ID_W  = 4;
  localparam int LEN_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write;
  logic [ID_W-1:0]   r2b_req_id;
  logic [1:0]        r2b_ba;
  logic [12:0]       r2b_raddr, r2b_caddr;
  logic [LEN_W-1:0]  r2b_len;
  logic              b2r_ack, b2r_arb_ok, b2x_req, b2x_row_hit;
  logic [ID_W-1:0]   b2x_id;
  logic              b2x_start, b2x_last, b2x_wrap, b2x_write;
  logic [1:0]        b2x_ba;
  logic [12:0]       b2x_raddr, b2x_caddr;
  logic [LEN_W-1:0]  b2x_len;
  logic [2:0]        b2x_count;
  logic              x2b_ack, x2b_pre_all;

  sdrc_bank_req_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .r2b_req(r2b_req), .r2b_req_id(r2b_req_id), .r2b_start(r2b_start),
    .r2b_last(r2b_last), .r2b_wrap(r2b_wrap), .r2b_write(r2b_write),
    .r2b_ba(r2b_ba), .r2b_raddr(r2b_raddr), .r2b_caddr(r2b_caddr), .r2b_len(r2b_len),
    .b2r_ack(b2r_ack), .b2r_arb_ok(b2r_arb_ok), .b2x_req(b2x_req),
    .b2x_id(b2x_id), .b2x_start(b2x_start), .b2x_last(b2x_last),
    .b2x_wrap(b2x_wrap), .b2x_write(b2x_write), .b2x_ba(b2x_ba),
    .b2x_raddr(b2x_raddr), .b2x_caddr(b2x_caddr), .b2x_len(b2x_len),
    .b2x_row_hit(b2x_row_hit), .b2x_count(b2x_count),
    .x2b_ack(x2b_ack), .x2b_pre_all(x2b_pre_all)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [3:0] id, input logic st, input logic la,
                       input logic wr, input logic we, input logic [1:0] ba,
                       input logic [12:0] ra, input logic [12:0] ca, input logic [11:0] ln);
    r2b_req = req; r2b_req_id = id; r2b_start = st; r2b_last = la; r2b_wrap = wr;
    r2b_write = we; r2b_ba = ba; r2b_raddr = ra; r2b_caddr = ca; r2b_len = ln;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] head_bits();
    return {b2x_id, b2x_start, b2x_last, b2x_wrap, b2x_write, b2x_ba, b2x_raddr, b2x_caddr, b2x_len};
  endfunction

  typedef struct {
    logic       req;
    logic [3:0] id;
    logic [1:0] ba;
    logic [12:0] ra;
    logic       xack;
    logic       pre;
    logic       e_ack;
    logic       e_arb;
    logic       e_breq;
    logic [2:0] e_cnt;
    logic       e_hit;
    logic [3:0] e_head;
  } vec_t;

  function automatic vec_t mk(logic req, logic [3:0] id, logic [1:0] ba, logic [12:0] ra,
                              logic xack, logic pre, logic ea, logic earb, logic ebr,
                              logic [2:0] ec, logic eh, logic [3:0] ehd);
    vec_t v;
    v.req = req; v.id = id; v.ba = ba; v.ra = ra; v.xack = xack; v.pre = pre;
    v.e_ack = ea; v.e_arb = earb; v.e_breq = ebr; v.e_cnt = ec; v.e_hit = eh; v.e_head = ehd;
    return v;
  endfunction

  vec_t vt [20];
  logic [47:0] sb [$];
  logic [47:0] rnd;

  initial begin
    // Expected values are the pre-edge outputs for the inputs on that row.
    vt[0]  = mk(0, 0, 0, 13'h000, 0, 0,  0, 1, 0, 0, 0, 0);
    vt[1]  = mk(1, 1, 1, 13'h123, 0, 0,  1, 1, 0, 0, 0, 0);
    vt[2]  = mk(1, 2, 1, 13'h123, 0, 0,  1, 1, 1, 1, 0, 1);
    vt[3]  = mk(1, 3, 1, 13'h124, 0, 0,  1, 1, 1, 2, 0, 1);
    vt[4]  = mk(1, 4, 2, 13'h0AA, 0, 0,  1, 0, 1, 3, 0, 1);
    vt[5]  = mk(1, 5, 0, 13'h001, 0, 0,  0, 0, 1, 4, 0, 1);
    vt[6]  = mk(1, 5, 0, 13'h001, 1, 0,  0, 0, 1, 4, 0, 1);
    vt[7]  = mk(1, 5, 0, 13'h001, 1, 0,  1, 0, 1, 3, 1, 2);
    vt[8]  = mk(0, 0, 0, 13'h000, 1, 0,  0, 0, 1, 3, 0, 3);
    vt[9]  = mk(0, 0, 0, 13'h000, 0, 0,  0, 1, 1, 2, 0, 4);
    vt[10] = mk(0, 0, 0, 13'h000, 1, 0,  0, 1, 1, 2, 0, 4);
    vt[11] = mk(1, 6, 2, 13'h0AA, 0, 0,  1, 1, 1, 1, 0, 5);
    vt[12] = mk(0, 0, 0, 13'h000, 1, 0,  0, 1, 1, 2, 0, 5);
    vt[13] = mk(0, 0, 0, 13'h000, 0, 0,  0, 1, 1, 1, 1, 6);
    vt[14] = mk(0, 0, 0, 13'h000, 1, 1,  0, 1, 1, 1, 1, 6);
    vt[15] = mk(1, 7, 2, 13'h0AA, 1, 0,  1, 1, 0, 0, 0, 0);
    vt[16] = mk(0, 0, 0, 13'h000, 0, 0,  0, 1, 1, 1, 0, 7);
    vt[17] = mk(0, 0, 0, 13'h000, 1, 0,  0, 1, 1, 1, 0, 7);
    vt[18] = mk(0, 0, 0, 13'h000, 1, 0,  0, 1, 0, 0, 0, 0);
    vt[19] = mk(0, 0, 0, 13'h000, 0, 0,  0, 1, 0, 0, 0, 0);

    reset_n = 1'b0; x2b_ack = 1'b0; x2b_pre_all = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    next_cycle();

    @(negedge clk);
    chk("rst_arb_ok", b2r_arb_ok, 1);
    chk("rst_b2x_req", b2x_req, 0);
    chk("rst_count", b2x_count, 0);
    chk("rst_ack", b2r_ack, 0);
    chk("rst_row_hit", b2x_row_hit, 0);
    chk("rst_fields", head_bits(), 0);
    next_cycle();

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].req, vt[i].id, 1'b1, 1'b1, 1'b0, vt[i].id[0], vt[i].ba, vt[i].ra,
            13'(vt[i].id), 12'(vt[i].id));
      x2b_ack = vt[i].xack; x2b_pre_all = vt[i].pre;
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), b2r_ack, vt[i].e_ack);
      chk($sformatf("v%0d_arb_ok", i), b2r_arb_ok, vt[i].e_arb);
      chk($sformatf("v%0d_b2x_req", i), b2x_req, vt[i].e_breq);
      chk($sformatf("v%0d_count", i), b2x_count, vt[i].e_cnt);
      chk($sformatf("v%0d_row_hit", i), b2x_row_hit, vt[i].e_hit);
      if (vt[i].e_breq) chk($sformatf("v%0d_head_id", i), b2x_id, vt[i].e_head);
      $display("vec %0d: ack=%0b arb_ok=%0b req=%0b cnt=%0d hit=%0b id=%0d",
               i, b2r_ack, b2r_arb_ok, b2x_req, b2x_count, b2x_row_hit, b2x_id);
      next_cycle();
    end
    x2b_ack = 1'b0; x2b_pre_all = 1'b0;

    // Single push: every field must come back unchanged one cycle later.
    drive(1, 4'd3, 1, 1, 0, 1, 2'd2, 13'h0A5, 13'h010, 12'd8);
    @(negedge clk);
    chk("single_ack", b2r_ack, 1);
    chk("single_not_fallthrough", b2x_req, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("single_req", b2x_req, 1);
    chk("single_fields", head_bits(), {4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 13'h0A5, 13'h010, 12'd8});
    chk("single_row_hit", b2x_row_hit, 0);
    chk("single_count", b2x_count, 1);
    $display("single push: id=%0d ba=%0d raddr=%0h len=%0d", b2x_id, b2x_ba, b2x_raddr, b2x_len);
    x2b_ack = 1'b1;
    next_cycle();
    x2b_ack = 1'b0;

    // Page-split pair on an idle bank; second chunk hits the row opened by the first.
    drive(1, 4'd9, 1, 0, 0, 0, 2'd3, 13'h055, 13'h010, 12'h0F0);
    next_cycle();
    drive(1, 4'd9, 0, 1, 0, 0, 2'd3, 13'h055, 13'h000, 12'h010);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("split_count", b2x_count, 2);
    chk("split_arb_ok", b2r_arb_ok, 1);
    chk("split_first_last", b2x_last, 0);
    chk("split_first_len", b2x_len, 12'h0F0);
    chk("split_first_caddr", b2x_caddr, 13'h010);
    x2b_ack = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("split_second_last", b2x_last, 1);
    chk("split_second_start", b2x_start, 0);
    chk("split_second_len", b2x_len, 12'h010);
    chk("split_second_caddr", b2x_caddr, 13'h000);
    chk("split_second_hit", b2x_row_hit, 1);
    $display("page split: second chunk len=%0h last=%0b hit=%0b", b2x_len, b2x_last, b2x_row_hit);
    next_cycle();
    x2b_ack = 1'b0;
    @(negedge clk);
    chk("split_drained", b2x_count, 0);
    next_cycle();

    // Random push/pop traffic against a queue model, then drain.
    for (int i = 0; i < 14; i++) begin
      rnd = {$urandom, $urandom};
      r2b_req = (i < 10);
      {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
       r2b_ba, r2b_raddr, r2b_caddr, r2b_len} = rnd;
      x2b_ack = (i >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("rnd%0d_count", i), b2x_count, sb.size());
      chk($sformatf("rnd%0d_ack", i), b2r_ack, r2b_req && (sb.size() < DEPTH));
      if (sb.size() > 0) chk($sformatf("rnd%0d_head", i), head_bits(), sb[0]);
      $display("rnd %0d: push=%0b pop=%0b cnt=%0d", i, b2r_ack, x2b_ack && b2x_req, b2x_count);
      if (x2b_ack && sb.size() > 0) void'(sb.pop_front());
      if (r2b_req && sb.size() < DEPTH + ((x2b_ack && b2x_req) ? 0 : 0) && b2r_ack) sb.push_back(rnd);
      next_cycle();
    end
    r2b_req = 1'b0; x2b_ack = 1'b0;
    @(negedge clk);
    chk("rnd_final_count", b2x_count, sb.size());
    next_cycle();
    while (sb.size() > 0) begin
      x2b_ack = 1'b1;
      @(negedge clk);
      chk("rnd_drain_head", head_bits(), sb[0]);
      void'(sb.pop_front());
      next_cycle();
    end
    x2b_ack = 1'b0;

    // Asynchronous reset with two chunks queued takes effect before the next edge.
    drive(1, 4'd1, 1, 0, 0, 0, 2'd1, 13'h011, 13'h000, 12'd4);
    next_cycle();
    drive(1, 4'd2, 0, 1, 0, 0, 2'd1, 13'h011, 13'h004, 12'd4);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_count", b2x_count, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", b2x_count, 0);
    chk("async_rst_req", b2x_req, 0);
    chk("async_rst_arb_ok", b2r_arb_ok, 1);
    chk("async_rst_fields", head_bits(), 0);
    $display("async reset: cnt=%0d req=%0b", b2x_count, b2x_req);
    #1 reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("post_reset_count", b2x_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
